// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle used by imem_loader.
// master = byte source / memory side, slave = the loader itself.
interface imem_loader_if #(
  parameter int ADDR_W = 64
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-serial program loader: packs little-endian bytes into 32-bit words and writes them to imem.
// Optional running byte checksum is built only when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 4,
  localparam int               CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] word_count,
  output logic [7:0]       checksum
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state;
  logic [1:0]        byte_idx;
  logic [31:0]       buffer;
  logic              last_seen;
  logic [ADDR_W-1:0] addr;
  logic              in_ready_r;
  logic              mem_we_r;
  logic              accept;

  // in_ready_r is only ever high in COLLECT, so this is the byte-accept strobe
  assign accept        = in_ready_r & bus.in_valid;
  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = buffer;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      byte_idx   <= 2'd0;
      buffer     <= '0;
      last_seen  <= 1'b0;
      addr       <= BASE_ADDR;
      in_ready_r <= 1'b0;
      mem_we_r   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= COLLECT;
            byte_idx   <= 2'd0;
            buffer     <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
            addr       <= BASE_ADDR;
            in_ready_r <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        COLLECT: begin
          if (accept) begin
            buffer[{byte_idx, 3'b000} +: 8] <= bus.in_data;
            if (byte_idx == 2'd3 || bus.in_last) begin
              state      <= WRITE;
              last_seen  <= bus.in_last;
              in_ready_r <= 1'b0;
              mem_we_r   <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        WRITE: begin
          mem_we_r   <= 1'b0;
          addr       <= addr + ADDR_W'(4);
          word_count <= word_count + CNT_W'(1);
          byte_idx   <= 2'd0;
          buffer     <= '0;
          // Running out of capacity without seeing in_last is reported as overflow
          if (last_seen || (word_count + CNT_W'(1)) == CNT_W'(MAX_WORDS)) begin
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            overflow <= !last_seen;
          end else begin
            state      <= COLLECT;
            in_ready_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic       launch;
  logic [7:0] sum;

  assign launch   = start && (state == IDLE || state == DONE);
  assign checksum = sum;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum <= 8'h00;
    end else if (launch) begin
      sum <= 8'h00;
    end else if (accept) begin
      sum <= sum + bus.in_data;
    end
  end
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader with hand-written timing and reset-mid-load sequences.
module tb_imem_loader;
  localparam int ADDR_W    = 64;
  localparam int MAX_WORDS = 4;

  typedef struct packed {
    logic [19:0][7:0] data;
    logic [4:0]       n;
    logic             has_last;
    logic [4:0]       last_idx;
    logic             stall;
    logic [4:0]       exp_accepted;
    logic [2:0]       exp_writes;
    logic [3:0][31:0] exp_words;
    logic             exp_overflow;
    logic [2:0]       exp_count;
    logic [7:0]       exp_sum;
  } vec_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [2:0] word_count;
  logic [7:0] checksum;

  int n_checks = 0;
  int n_fails  = 0;

  logic [63:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(64'h0),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .word_count(word_count),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " in_ready"},   64'(bus.in_ready),  64'd0);
    checkOutput({tag, " mem_we"},     64'(bus.mem_we),    64'd0);
    checkOutput({tag, " busy"},       64'(busy),          64'd0);
    checkOutput({tag, " done"},       64'(done),          64'd0);
    checkOutput({tag, " overflow"},   64'(overflow),      64'd0);
    checkOutput({tag, " mem_addr"},   bus.mem_addr,       64'd0);
    checkOutput({tag, " mem_wdata"},  64'(bus.mem_wdata), 64'd0);
    checkOutput({tag, " word_count"}, 64'(word_count),    64'd0);
    checkOutput({tag, " checksum"},   64'(checksum),      64'd0);
  endtask

  task automatic startLoad();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Source holds each byte until accepted; optional stall drops in_valid every other cycle
  task automatic applyStimulus(input vec_t v, output int accepted);
    int   cycles;
    logic acc;
    cycles   = 0;
    accepted = 0;
    while (accepted < int'(v.n) && cycles < 80) begin
      bus.in_valid = !(v.stall && cycles[0]);
      bus.in_data  = v.data[accepted];
      bus.in_last  = v.has_last && (accepted == int'(v.last_idx));
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) accepted++;
      cycles++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    for (int c = 0; c < 20 && done !== 1'b1; c++) @(negedge clk);
    checkOutput({tag, " done"}, 64'(done), 64'd1);
  endtask

  function automatic logic [7:0] expSum(input logic [7:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    return s;
`else
    return (s == s) ? 8'h00 : 8'h00;
`endif
  endfunction

  initial begin
    vec_t vecs[4];
    vec_t rv;
    int   acc;

    for (int i = 0; i < 4; i++) vecs[i] = '0;

    vecs[0].data[0] = 8'h83; vecs[0].data[1] = 8'h34;
    vecs[0].data[2] = 8'h85; vecs[0].data[3] = 8'h02;
    vecs[0].n = 5'd4; vecs[0].has_last = 1'b1; vecs[0].last_idx = 5'd3;
    vecs[0].exp_accepted = 5'd4; vecs[0].exp_writes = 3'd1;
    vecs[0].exp_words[0] = 32'h0285_3483;
    vecs[0].exp_count = 3'd1; vecs[0].exp_sum = 8'h3E;

    vecs[1].data[0] = 8'h83; vecs[1].data[1] = 8'h34;
    vecs[1].data[2] = 8'h85; vecs[1].data[3] = 8'h02;
    vecs[1].data[4] = 8'hB3; vecs[1].data[5] = 8'h84;
    vecs[1].data[6] = 8'h9A; vecs[1].data[7] = 8'h00;
    vecs[1].n = 5'd8; vecs[1].has_last = 1'b1; vecs[1].last_idx = 5'd7; vecs[1].stall = 1'b1;
    vecs[1].exp_accepted = 5'd8; vecs[1].exp_writes = 3'd2;
    vecs[1].exp_words[0] = 32'h0285_3483; vecs[1].exp_words[1] = 32'h009A_84B3;
    vecs[1].exp_count = 3'd2; vecs[1].exp_sum = 8'h0F;

    vecs[2].data[0] = 8'h93; vecs[2].data[1] = 8'h84;
    vecs[2].n = 5'd2; vecs[2].has_last = 1'b1; vecs[2].last_idx = 5'd1;
    vecs[2].exp_accepted = 5'd2; vecs[2].exp_writes = 3'd1;
    vecs[2].exp_words[0] = 32'h0000_8493;
    vecs[2].exp_count = 3'd1; vecs[2].exp_sum = 8'h17;

    for (int i = 0; i < 20; i++) vecs[3].data[i] = 8'(i + 1);
    vecs[3].n = 5'd20;
    vecs[3].exp_accepted = 5'd16; vecs[3].exp_writes = 3'd4;
    vecs[3].exp_words[0] = 32'h0403_0201; vecs[3].exp_words[1] = 32'h0807_0605;
    vecs[3].exp_words[2] = 32'h0C0B_0A09; vecs[3].exp_words[3] = 32'h100F_0E0D;
    vecs[3].exp_overflow = 1'b1; vecs[3].exp_count = 3'd4; vecs[3].exp_sum = 8'h88;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkResetState("reset");

    // Back-to-back word: mem_we one cycle after last accept, done one cycle later; start while busy ignored
    wr_addr.delete(); wr_data.delete();
    startLoad();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vecs[0].data[i];
      bus.in_last  = (i == 3);
      start        = (i == 1);
      @(negedge clk);
      checkOutput("timing in_ready while collecting", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
    end
    start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    @(negedge clk);
    checkOutput("timing mem_we after last byte", 64'(bus.mem_we),    64'd1);
    checkOutput("timing mem_wdata",              64'(bus.mem_wdata), 64'h0285_3483);
    checkOutput("timing mem_addr",               bus.mem_addr,       64'h0);
    checkOutput("timing in_ready in write",      64'(bus.in_ready),  64'd0);
    checkOutput("timing busy in write",          64'(busy),          64'd1);
    checkOutput("timing done in write",          64'(done),          64'd0);
    @(negedge clk);
    checkOutput("timing mem_we single cycle",    64'(bus.mem_we),    64'd0);
    checkOutput("timing done after write",       64'(done),          64'd1);
    checkOutput("timing busy after write",       64'(busy),          64'd0);
    checkOutput("timing word_count",             64'(word_count),    64'd1);

    for (int v = 0; v < 4; v++) begin
      wr_addr.delete(); wr_data.delete();
      startLoad();
      applyStimulus(vecs[v], acc);
      checkOutput($sformatf("vec%0d accepted bytes", v), 64'(acc), 64'(vecs[v].exp_accepted));
      waitDone($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d busy", v),       64'(busy),         64'd0);
      checkOutput($sformatf("vec%0d in_ready", v),   64'(bus.in_ready), 64'd0);
      checkOutput($sformatf("vec%0d overflow", v),   64'(overflow),     64'(vecs[v].exp_overflow));
      checkOutput($sformatf("vec%0d word_count", v), 64'(word_count),   64'(vecs[v].exp_count));
      checkOutput($sformatf("vec%0d checksum", v),   64'(checksum),     64'(expSum(vecs[v].exp_sum)));
      checkOutput($sformatf("vec%0d held mem_addr", v), bus.mem_addr, 64'(vecs[v].exp_count) * 64'd4);
      checkOutput($sformatf("vec%0d write count", v), 64'(wr_addr.size()), 64'(vecs[v].exp_writes));
      for (int w = 0; w < int'(vecs[v].exp_writes) && w < wr_addr.size(); w++) begin
        checkOutput($sformatf("vec%0d write%0d addr", v, w), wr_addr[w], 64'(w) * 64'd4);
        checkOutput($sformatf("vec%0d write%0d data", v, w), 64'(wr_data[w]), 64'(vecs[v].exp_words[w]));
      end
    end

    // Reset after two accepted bytes: partial word dropped, next load restarts at base
    wr_addr.delete(); wr_data.delete();
    startLoad();
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h11 * 8'(i + 1);
      bus.in_last  = 1'b0;
      @(negedge clk);
      checkOutput("midreset in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checkResetState("midreset");
    repeat (3) @(negedge clk);
    checkOutput("midreset no write", 64'(wr_addr.size()), 64'd0);

    rv = '0;
    rv.data[0] = 8'hAA; rv.data[1] = 8'hBB; rv.data[2] = 8'hCC; rv.data[3] = 8'hDD;
    rv.n = 5'd4; rv.has_last = 1'b1; rv.last_idx = 5'd3;
    startLoad();
    applyStimulus(rv, acc);
    checkOutput("reload accepted bytes", 64'(acc), 64'd4);
    waitDone("reload");
    checkOutput("reload write count", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() > 0) begin
      checkOutput("reload write addr", wr_addr[0], 64'h0);
      checkOutput("reload write data", 64'(wr_data[0]), 64'hDDCC_BBAA);
    end
    checkOutput("reload word_count", 64'(word_count), 64'd1);
    checkOutput("reload checksum",   64'(checksum),   64'(expSum(8'h0E)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
